// File: rtl/fpu_arb_pkg.sv
// Shared types for the FPU memory-port arbiter and its round-robin picker.
package fpu_arb_pkg;

   localparam int unsigned FPU_ARB_NREQ = 4;

   typedef logic [1:0] req_idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/fpu_rr_picker.sv
// Combinational round-robin picker: returns the first eligible index after
// the last-granted one, wrapping modulo NREQ.
module fpu_rr_picker
   import fpu_arb_pkg::*;
#(
   parameter int unsigned NREQ = FPU_ARB_NREQ
) (
   input  logic [NREQ-1:0] i_elig,
   input  req_idx_t        i_last,
   output req_idx_t        o_idx,
   output logic            o_found
);

   // Scan last+1 .. last+NREQ and take the first eligible requester.
   always_comb begin
      req_idx_t w_j;
      o_idx   = i_last;
      o_found = 1'b0;
      w_j     = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         w_j = req_idx_t'((32'(i_last) + k) % NREQ);
         if (!o_found && i_elig[w_j]) begin
            o_found = 1'b1;
            o_idx   = w_j;
         end
      end
   end

endmodule

// File: rtl/fpu_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among the FPU operand/result
// handles. Optional watchdog on the memory ack is enabled by FPU_ARB_WDOG_EN.
module fpu_mem_arbiter
   import fpu_arb_pkg::*;
#(
   parameter int unsigned NREQ        = FPU_ARB_NREQ,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WDOG_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst_l,
   input  logic [NREQ-1:0]        req_avail,
   input  logic [NREQ-1:0]        req_r_en,
   input  logic [NREQ-1:0]        req_w_en,
   input  logic [NREQ*ADDR_W-1:0] req_ptr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        req_done,
   output logic [DATA_W-1:0]      rdata,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic                   mem_ack,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic                   busy,
   output logic [1:0]             grant_id,
   output logic                   err
);

   arb_state_t          r_state, w_state_nxt;
   req_idx_t            r_last, r_grant, w_pick;
   logic                w_found, w_timeout;
   logic [NREQ-1:0]     w_elig, w_grant_oh, r_done;
   logic                r_mem_req, r_mem_we, w_sel_we;
   logic [ADDR_W-1:0]   r_mem_addr, w_sel_ptr;
   logic [DATA_W-1:0]   r_mem_wdata, w_sel_wdata, r_rdata;

   assign w_elig = req_avail & (req_r_en | req_w_en);

   fpu_rr_picker #(.NREQ(NREQ)) u_pick (
      .i_elig  (w_elig),
      .i_last  (r_last),
      .o_idx   (w_pick),
      .o_found (w_found)
   );

   // Select the picked requester's operation, pointer and write data.
   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_ptr   = '0;
      w_sel_wdata = '0;
      w_grant_oh  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_pick == req_idx_t'(i)) begin
            w_sel_we    = req_w_en[i];
            w_sel_ptr   = req_ptr[i*ADDR_W +: ADDR_W];
            w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
         if (r_grant == req_idx_t'(i)) w_grant_oh[i] = 1'b1;
      end
   end

`ifdef FPU_ARB_WDOG_EN
   localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
   logic [WDOG_W-1:0] r_wdog;
   logic              r_err;

   assign w_timeout = (r_state == ISSUE) && !mem_ack &&
                      (r_wdog == WDOG_W'(WDOG_CYCLES - 1));

   // Count unacknowledged ISSUE cycles; flag a sticky error on expiry.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         if (r_state != ISSUE)
            r_wdog <= '0;
         else if (!mem_ack)
            r_wdog <= r_wdog + WDOG_W'(1);
         if (w_timeout)
            r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
   // The watchdog limit has no effect in this build.
   if (WDOG_CYCLES == 0) begin : g_wdog_unused
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_found) w_state_nxt = ISSUE;
         ISSUE:   if (mem_ack || w_timeout) w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Registered grant bookkeeping, memory-side outputs and response.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_last      <= req_idx_t'(NREQ - 1);
         r_grant     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_done      <= '0;
         r_rdata     <= '0;
      end else begin
         r_done <= '0;
         unique case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_grant     <= w_pick;
                  r_last      <= w_pick;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= w_sel_we;
                  r_mem_addr  <= w_sel_ptr;
                  r_mem_wdata <= w_sel_wdata;
               end
            end
            ISSUE: begin
               if (mem_ack || w_timeout) begin
                  r_mem_req <= 1'b0;
                  r_done    <= w_grant_oh;
                  r_rdata   <= (mem_ack && !r_mem_we) ? mem_rdata : '0;
               end
            end
            RESP: r_rdata <= '0;
            default: ;
         endcase
      end
   end

   assign req_done  = r_done;
   assign rdata     = r_rdata;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign grant_id  = r_grant;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fpu_mem_arbiter.sv
// Directed, table-driven bench for fpu_mem_arbiter.
module tb_fpu_mem_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;

   logic              clk = 1'b0;
   logic              rst_l;
   logic [NREQ-1:0]   req_avail, req_r_en, req_w_en;
   logic [NREQ*AW-1:0] req_ptr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]   req_done;
   logic [DW-1:0]     rdata;
   logic              mem_req, mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic              mem_ack;
   logic [DW-1:0]     mem_rdata;
   logic              busy;
   logic [1:0]        grant_id;
   logic              err;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   fpu_mem_arbiter #(
      .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .WDOG_CYCLES(8)
   ) dut (
      .clk(clk), .rst_l(rst_l),
      .req_avail(req_avail), .req_r_en(req_r_en), .req_w_en(req_w_en),
      .req_ptr(req_ptr), .req_wdata(req_wdata),
      .req_done(req_done), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy), .grant_id(grant_id), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_reqs();
      req_avail = '0; req_r_en = '0; req_w_en = '0;
      req_ptr = '0; req_wdata = '0;
   endtask

   task automatic set_req(input int unsigned i, input logic av, input logic r,
                          input logic w, input logic [31:0] ptr, input logic [31:0] wd);
      req_avail[i] = av;
      req_r_en[i]  = r;
      req_w_en[i]  = w;
      req_ptr[i*AW +: AW]   = ptr;
      req_wdata[i*DW +: DW] = wd;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_done"},  64'(req_done), 64'h0);
      chk({tag, "_rdata"}, 64'(rdata), 64'h0);
      chk({tag, "_mreq"},  64'(mem_req), 64'h0);
      chk({tag, "_mwe"},   64'(mem_we), 64'h0);
      chk({tag, "_maddr"}, 64'(mem_addr), 64'h0);
      chk({tag, "_mwd"},   64'(mem_wdata), 64'h0);
      chk({tag, "_busy"},  64'(busy), 64'h0);
      chk({tag, "_gid"},   64'(grant_id), 64'h0);
      chk({tag, "_err"},   64'(err), 64'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_l = 1'b0;
      @(negedge clk);
      rst_l = 1'b1;
   endtask

   typedef struct {
      int unsigned idx;
      logic        av, r, w;
      logic [31:0] ptr, wdata, mrdata;
      logic        exp_grant;
      logic        exp_we;
      logic [3:0]  exp_done;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];
   logic [1:0] order[5];

   initial begin
      rst_l = 1'b0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      clear_reqs();

      vecs[0] = '{2, 1, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1, 0, 4'b0100, 32'hDEADBEEF};
      vecs[1] = '{0, 1, 0, 1, 32'h5, 32'h3F800000, 32'h12345678, 1, 1, 4'b0001, 32'h0};
      vecs[2] = '{3, 1, 1, 1, 32'hABC, 32'h55AA, 32'h77777777, 1, 1, 4'b1000, 32'h0};
      vecs[3] = '{1, 1, 0, 0, 32'h44, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0};
      vecs[4] = '{1, 1, 1, 0, 32'hFFFFFFFF, 32'h0, 32'hCAFEF00D, 1, 0, 4'b0010, 32'hCAFEF00D};

      // Reset state.
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_l = 1'b1;

      // Table-driven single transactions, zero-wait memory.
      for (int v = 0; v < 5; v++) begin
         clear_reqs();
         set_req(vecs[v].idx, vecs[v].av, vecs[v].r, vecs[v].w, vecs[v].ptr, vecs[v].wdata);
         @(negedge clk);
         chk($sformatf("v%0d_mreq", v), 64'(mem_req), 64'(vecs[v].exp_grant));
         if (vecs[v].exp_grant) begin
            chk($sformatf("v%0d_mwe", v),   64'(mem_we), 64'(vecs[v].exp_we));
            chk($sformatf("v%0d_maddr", v), 64'(mem_addr), 64'(vecs[v].ptr));
            if (vecs[v].exp_we)
               chk($sformatf("v%0d_mwd", v), 64'(mem_wdata), 64'(vecs[v].wdata));
            chk($sformatf("v%0d_gid", v),   64'(grant_id), 64'(vecs[v].idx));
            chk($sformatf("v%0d_done0", v), 64'(req_done), 64'h0);
            mem_ack = 1'b1;
            mem_rdata = vecs[v].mrdata;
            @(negedge clk);
            mem_ack = 1'b0;
            chk($sformatf("v%0d_done", v),  64'(req_done), 64'(vecs[v].exp_done));
            chk($sformatf("v%0d_rdata", v), 64'(rdata), 64'(vecs[v].exp_rdata));
            chk($sformatf("v%0d_mreq_r", v), 64'(mem_req), 64'h0);
            clear_reqs();
            @(negedge clk);
            chk($sformatf("v%0d_done_end", v), 64'(req_done), 64'h0);
         end else begin
            chk($sformatf("v%0d_busy", v), 64'(busy), 64'h0);
            clear_reqs();
         end
         chk($sformatf("v%0d_idle", v), 64'(busy), 64'h0);
      end

      // Contention: all four eligible from reset, rotation 0,1,2,3,0.
      order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
      @(negedge clk);
      rst_l = 1'b0;
      clear_reqs();
      for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1, 1, 0, 32'h100 + i, 32'h0);
      mem_ack = 1'b1;
      mem_rdata = 32'hA5A50000;
      @(negedge clk);
      rst_l = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k % 3 == 1) begin
            chk($sformatf("rr_k%0d_mreq", k), 64'(mem_req), 64'h1);
            chk($sformatf("rr_k%0d_gid", k), 64'(grant_id), 64'(order[(k-1)/3]));
            chk($sformatf("rr_k%0d_addr", k), 64'(mem_addr), 64'(32'h100 + order[(k-1)/3]));
         end
         if (k % 3 == 2) begin
            chk($sformatf("rr_k%0d_done", k), 64'(req_done), 64'(4'b0001 << order[(k-2)/3]));
            chk($sformatf("rr_k%0d_rdata", k), 64'(rdata), 64'hA5A50000);
         end else begin
            chk($sformatf("rr_k%0d_nodone", k), 64'(req_done), 64'h0);
         end
      end
      mem_ack = 1'b0;
      clear_reqs();

      // Wait states: ack after 5 idle ISSUE cycles, mem_* stable for 6 cycles.
      do_reset();
      set_req(1, 1, 0, 1, 32'h77, 32'h99);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("ws%0d_mreq", i), 64'(mem_req), 64'h1);
         chk($sformatf("ws%0d_mwe", i), 64'(mem_we), 64'h1);
         chk($sformatf("ws%0d_maddr", i), 64'(mem_addr), 64'h77);
         chk($sformatf("ws%0d_mwd", i), 64'(mem_wdata), 64'h99);
         chk($sformatf("ws%0d_nodone", i), 64'(req_done), 64'h0);
         if (i == 0) set_req(1, 1, 0, 1, 32'hBAD, 32'hBAD);
         if (i == 5) mem_ack = 1'b1;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      chk("ws_done", 64'(req_done), 64'b0010);
      chk("ws_rdata", 64'(rdata), 64'h0);
      clear_reqs();
      @(negedge clk);
      chk("ws_after", 64'(req_done), 64'h0);

      // Asynchronous reset while mem_req is high.
      do_reset();
      set_req(1, 1, 1, 0, 32'h1111, 32'h0);
      @(negedge clk);
      chk("rst_pre_mreq", 64'(mem_req), 64'h1);
      #2;
      rst_l = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      clear_reqs();
      set_req(0, 1, 1, 0, 32'h2000, 32'h0);
      set_req(2, 1, 1, 0, 32'h3000, 32'h0);
      @(negedge clk);
      chk("rst_held_done", 64'(req_done), 64'h0);
      rst_l = 1'b1;
      @(negedge clk);
      chk("rst_post_mreq", 64'(mem_req), 64'h1);
      chk("rst_post_gid", 64'(grant_id), 64'h0);
      chk("rst_post_addr", 64'(mem_addr), 64'h2000);
      mem_ack = 1'b1;
      mem_rdata = 32'h0BADF00D;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("rst_post_done", 64'(req_done), 64'b0001);
      chk("rst_post_rdata", 64'(rdata), 64'h0BADF00D);
      clear_reqs();
      @(negedge clk);

`ifdef FPU_ARB_WDOG_EN
      // Watchdog: no ack ever; done after 8 ISSUE cycles with rdata 0, sticky err.
      do_reset();
      set_req(2, 1, 1, 0, 32'h40, 32'h0);
      mem_rdata = 32'hFFFFFFFF;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk($sformatf("wd%0d_mreq", i), 64'(mem_req), 64'h1);
         chk($sformatf("wd%0d_nodone", i), 64'(req_done), 64'h0);
         chk($sformatf("wd%0d_err", i), 64'(err), 64'h0);
      end
      @(negedge clk);
      chk("wd_done", 64'(req_done), 64'b0100);
      chk("wd_rdata", 64'(rdata), 64'h0);
      chk("wd_err", 64'(err), 64'h1);
      chk("wd_mreq", 64'(mem_req), 64'h0);
      clear_reqs();
      repeat (4) @(negedge clk);
      chk("wd_err_sticky", 64'(err), 64'h1);
      do_reset();
      chk("wd_err_cleared", 64'(err), 64'h0);
`else
      @(negedge clk);
      chk("err_tied", 64'(err), 64'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fpu_mem_arbiter.md
# fpu_mem_arbiter

Round-robin arbiter that shares one memory port among the FPU job manager's operand/result handles (a, b, c, d). It sits between the FPU sequencing FSMs and the memory, and serializes their per-word read and write requests. Each requester sees the same avail/done handshake it would see from a dedicated port.

## Interface
- NREQ, 4, number of requesters; index 0..3 maps to handles a, b, c, d
- ADDR_W, 32, word pointer width
- DATA_W, 32, data word width
- WDOG_CYCLES, 64, watchdog limit in cycles; used only with FPU_ARB_WDOG_EN
- clk  in  1  clock; all state updates on rising edge
- rst_l  in  1  asynchronous active-low reset
- req_avail  in  NREQ  requester i has a pending access
- req_r_en  in  NREQ  read request qualifier
- req_w_en  in  NREQ  write request qualifier
- req_ptr  in  NREQ×ADDR_W  per-requester word address
- req_wdata  in  NREQ×DATA_W  per-requester write data
- req_done  out  NREQ  one-cycle completion pulse, one-hot
- rdata  out  DATA_W  read data; valid while req_done is nonzero
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory accepted/completed the access this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- busy  out  1  FSM not in IDLE
- grant_id  out  2  index of current or last granted requester
- err  out  1  sticky watchdog error

## Operation
- Reset values: all outputs 0, state IDLE, last-grant pointer = NREQ-1, so requester 0 wins first.
- Eligibility: a requester is eligible when req_avail=1 and (req_r_en or req_w_en). avail with neither qualifier is ignored. If both qualifiers are set, the access is a write.
- States:
  - IDLE: if any requester is eligible, pick the first eligible index in the order last+1, last+2, …, wrapping mod NREQ. Latch the index, op, ptr and wdata into registers, update the last-grant pointer, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive mem_req=1 with mem_we, mem_addr and mem_wdata from the latched registers. On mem_ack, capture mem_rdata (writes capture 0) and go to RESP.
  - RESP: req_done[grant]=1 and rdata valid for exactly one cycle, then go to IDLE.
- Requester inputs are sampled only in IDLE. Changes while the requester is granted are ignored.
- The requester drops avail at the same edge where it sees done. Because RESP always returns to IDLE, the finished request cannot be re-granted twice.
- If several requesters are eligible simultaneously, each is served once in rotation before any repeats.
- Asynchronous reset mid-transaction: the FSM returns to IDLE immediately and mem_req drops. Memory must discard any partially issued access, and no done pulse is produced.

## Timing
- With a zero-wait memory (mem_ack in the first ISSUE cycle), the sequence is:
  - cycle 0: eligible request seen in IDLE
  - cycle 1: mem_req=1
  - cycle 2: req_done pulse
- Throughput: one access per 3 cycles plus memory wait cycles.
- mem_req, mem_we, mem_addr, mem_wdata, req_done, rdata and grant_id are all registered.
- mem_* outputs are stable for the whole ISSUE dwell. mem_req is 0 in IDLE and RESP.

## Configuration
- FPU_ARB_WDOG_EN defined:
  - a counter clears on entry to ISSUE and increments each ISSUE cycle without mem_ack.
  - When it reaches WDOG_CYCLES, the FSM goes to RESP with rdata=0, pulses req_done and sets err.
  - err stays set until reset.
- FPU_ARB_WDOG_EN undefined: no counter, err is tied 0, and ISSUE waits indefinitely for mem_ack.

## Structure
- Package fpu_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, RESP}
  - the default NREQ
  - req_idx_t typedef (2 bits)
- Sub-module fpu_rr_picker: combinational. Inputs are the eligibility vector and the last-grant pointer; outputs are the chosen index and a found flag. It is reused by other FPU schedulers.

## Test plan
- Single read: req 2 reads ptr 0x10, memory acks on first cycle with 0xDEADBEEF → mem_req in cycle 1, req_done=4'b0100 with rdata=0xDEADBEEF in cycle 2.
- Single write: req 0 writes 0x3F800000 to ptr 5 → mem_we=1, mem_addr=5, mem_wdata=0x3F800000; req_done=4'b0001; rdata=0.
- Contention: all four requesters held eligible from reset → grant order 0, 1, 2, 3, 0; each done 3 cycles apart with zero-wait memory.
- Wait states: mem_ack delayed 5 cycles → mem_* held constant for 6 ISSUE cycles; done one cycle after the ack.
- Reset mid-ISSUE: rst_l low while mem_req=1 → all outputs 0 immediately. After release, req 0 wins first again.
- Watchdog (FPU_ARB_WDOG_EN, WDOG_CYCLES=8): mem_ack never arrives → done pulse with rdata=0 after 8 ISSUE cycles, err=1 and stays 1 until reset.
